interval_capture: RTL and testbench
===================================

Name: interval_capture

Overview:
- Measures elapsed milliseconds between a start event and a stop event. It is the measuring counterpart of the countdown/count-up timer that generates timeouts.
- Used for reaction-time measurement: the game FSM pulses start when the stimulus shows, and the player's button drives stop.
- The result is held with a valid flag until the consumer acknowledges it.
- Saturates with a timeout flag if stop never arrives.

Parameters:
MAX_MS, 2000, maximum measurable interval in ms; reaching it ends the measurement with timeout
CLKS_PER_MS, 50000, clock cycles per millisecond (50 MHz clk)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
start  input  1  level, synchronous to clk; rising edge begins a measurement
stop  input  1  level, synchronous to clk; rising edge ends a measurement
ack  input  1  consumer acknowledge; high for one or more cycles releases the held result
elapsed_ms  output  $clog2(MAX_MS+1)  captured interval in whole ms
result_valid  output  1  high while a result (normal or timeout) is held
timeout  output  1  high with result_valid when MAX_MS was reached without stop
busy  output  1  high while measuring

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE; prescaler, ms count and edge-detect registers clear to 0.
  - elapsed_ms, result_valid, timeout and busy are all 0.
- Edge detect:
  - start_q and stop_q register the inputs every clk.
  - start_rise = start & ~start_q; stop_rise = stop & ~stop_q.
  - A start held high while reset deasserts produces a rise on the first clk.
- Counter widths:
  - Prescaler is $clog2(CLKS_PER_MS) bits and counts 0..CLKS_PER_MS-1.
  - tick = (prescaler == CLKS_PER_MS-1) while in RUN.
  - The ms count is $clog2(MAX_MS+1) bits and never wraps.
- State IDLE (busy=0):
  - start_rise: go to RUN, clear prescaler and ms count, busy=1 from the next cycle.
  - stop_rise and ack are ignored.
  - If start_rise and stop_rise occur in the same cycle, start is taken and stop is discarded.
- State RUN (busy=1):
  - The prescaler increments every cycle.
  - On tick: prescaler resets to 0 and the ms count increments.
  - stop_rise: go to HOLD.
    - elapsed_ms = current ms count (whole completed ms, truncated), result_valid=1, timeout=0, busy=0, all registered at that clk edge.
    - Latency is one clk from the sampled stop rise.
  - stop_rise coincident with tick: stop has priority; the coincident tick is not counted.
  - Tick that brings the ms count to MAX_MS with no stop_rise: go to HOLD with elapsed_ms=MAX_MS, result_valid=1, timeout=1, busy=0.
  - start_rise and ack are ignored.
- State HOLD:
  - elapsed_ms, result_valid and timeout are stable.
  - ack=1: go to IDLE; result_valid=0 and timeout=0 on the next edge; elapsed_ms keeps its last value.
  - start_rise and stop_rise are ignored, including a start_rise in the same cycle as ack. A new measurement needs a fresh start rise while in IDLE.
- Reset mid-operation: abandons any measurement immediately; no result is produced.
- Outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
All scenarios use CLKS_PER_MS=4, MAX_MS=10; Pn is the n-th posedge after the start rise is sampled at P0.
- Normal measurement:
  - Stimulus: start rise sampled at P0, stop rise sampled at P14.
  - Required: busy=1 from P0 to P14; ticks at P4, P8, P12; after P14 elapsed_ms=3, result_valid=1, timeout=0, busy=0.
- Stop coincident with tick:
  - Stimulus: stop rise sampled at P8.
  - Required: elapsed_ms=1, not 2.
- Timeout:
  - Stimulus: no stop.
  - Required: after P40, elapsed_ms=10, timeout=1, result_valid=1, busy=0.
  - A stop rise at P45 changes nothing.
- Hold and acknowledge:
  - Stimulus: while in HOLD with elapsed_ms=3, pulse start (ignored), then ack for 1 cycle together with a start rise.
  - Required: result_valid=0 and timeout=0 next cycle; the state returns to IDLE and does not start a run.
  - A later start rise begins a new run with the ms count from 0.
- Reset mid-run:
  - Stimulus: drive reset=0 asynchronously between P5 and P6 while start is held high, then release.
  - Required: all outputs are 0 immediately; the first clk after release detects a start rise and busy=1.
- IDLE corner cases:
  - Stimulus: stop rise alone in IDLE.
  - Required: no state change.
  - Stimulus: start and stop rising in the same cycle.
  - Required: RUN is entered; a second stop rise 6 cycles later gives elapsed_ms=1.

Source files
------------

// File: rtl/interval_capture.sv
// interval_capture: measures whole milliseconds between a start rise and a stop rise.
// Ports: clk, reset (async, active-low), start/stop (levels, rising edges used), ack (releases result);
//        elapsed_ms/result_valid/timeout hold the result, busy flags an active measurement.
module interval_capture #(
    parameter int MAX_MS      = 2000,
    parameter int CLKS_PER_MS = 50000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         stop,
    input  logic                         ack,
    output logic [$clog2(MAX_MS+1)-1:0]  elapsed_ms,
    output logic                         result_valid,
    output logic                         timeout,
    output logic                         busy
);

    localparam int MW = $clog2(MAX_MS + 1);
    // Guard against a zero-width prescaler when one clock equals one millisecond.
    localparam int PW = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            start_q;
    logic            stop_q;
    logic            start_rise;
    logic            stop_rise;
    logic [PW-1:0]   presc;
    logic [MW-1:0]   ms_cnt;
    logic            tick;
    logic            at_limit;

    assign start_rise = start & ~start_q;
    assign stop_rise  = stop  & ~stop_q;
    assign tick       = (state == RUN) && (presc == PW'(CLKS_PER_MS - 1));
    // The tick that lands here brings the count to MAX_MS.
    assign at_limit   = (ms_cnt == MW'(MAX_MS - 1));

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                // A coincident stop rise is simply not looked at here.
                if (start_rise) state_nxt = RUN;
            end
            RUN: begin
                if (stop_rise)             state_nxt = HOLD;
                else if (tick && at_limit) state_nxt = HOLD;
            end
            HOLD: begin
                // Any start rise seen here, even alongside ack, is dropped.
                if (ack) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode from the state register only.
    always_comb begin
        busy = 1'b0;
        if (state == RUN) busy = 1'b1;
    end

    // Edge detectors, counters and the held result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            start_q      <= 1'b0;
            stop_q       <= 1'b0;
            presc        <= '0;
            ms_cnt       <= '0;
            elapsed_ms   <= '0;
            result_valid <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            start_q <= start;
            stop_q  <= stop;
            case (state)
                IDLE: begin
                    if (start_rise) begin
                        presc  <= '0;
                        ms_cnt <= '0;
                    end
                end
                RUN: begin
                    if (stop_rise) begin
                        // Stop wins over a coincident tick: that ms is not counted.
                        elapsed_ms   <= ms_cnt;
                        result_valid <= 1'b1;
                        timeout      <= 1'b0;
                    end else if (tick) begin
                        presc  <= '0;
                        ms_cnt <= ms_cnt + MW'(1);
                        if (at_limit) begin
                            elapsed_ms   <= MW'(MAX_MS);
                            result_valid <= 1'b1;
                            timeout      <= 1'b1;
                        end
                    end else begin
                        presc <= presc + PW'(1);
                    end
                end
                HOLD: begin
                    // elapsed_ms deliberately keeps its value after release.
                    if (ack) begin
                        result_valid <= 1'b0;
                        timeout      <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_interval_capture.sv
module tb_interval_capture;

    localparam int CLKS = 4;
    localparam int MAXM = 10;
    localparam int MW   = $clog2(MAXM + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          stop;
    logic          ack;
    logic [MW-1:0] elapsed_ms;
    logic          result_valid;
    logic          timeout;
    logic          busy;

    int checks = 0;
    int errors = 0;

    interval_capture #(.MAX_MS(MAXM), .CLKS_PER_MS(CLKS)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .stop         (stop),
        .ack          (ack),
        .elapsed_ms   (elapsed_ms),
        .result_valid (result_valid),
        .timeout      (timeout),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Reference model: counts clock edges since the start rise and derives
    // the millisecond result arithmetically.
    int m_mode;   // 0 idle, 1 measuring, 2 holding a result
    int m_n;      // edges elapsed since the start rise was sampled
    int m_el;
    bit m_rv;
    bit m_to;
    bit m_sq;
    bit m_pq;

    task automatic model_reset();
        m_mode = 0; m_n = 0; m_el = 0; m_rv = 0; m_to = 0; m_sq = 0; m_pq = 0;
    endtask

    task automatic model_edge(input bit s, input bit p, input bit a);
        bit sr;
        bit pr;
        sr = s & ~m_sq;
        pr = p & ~m_pq;
        m_sq = s;
        m_pq = p;
        case (m_mode)
            0: if (sr) begin m_mode = 1; m_n = 0; end
            1: begin
                m_n++;
                if (pr) begin
                    m_mode = 2; m_el = (m_n - 1) / CLKS; m_rv = 1; m_to = 0;
                end else if (m_n == MAXM * CLKS) begin
                    m_mode = 2; m_el = MAXM; m_rv = 1; m_to = 1;
                end
            end
            default: if (a) begin m_mode = 0; m_rv = 0; m_to = 0; end
        endcase
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_model(input string where);
        chk({where, ".elapsed_ms"},   int'(elapsed_ms),   m_el);
        chk({where, ".result_valid"}, int'(result_valid), int'(m_rv));
        chk({where, ".timeout"},      int'(timeout),      int'(m_to));
        chk({where, ".busy"},         int'(busy),         (m_mode == 1) ? 1 : 0);
    endtask

    // One clock: drive, let the edge happen, sample on the falling edge.
    task automatic cyc(input bit s, input bit p, input bit a, input string where);
        start = s; stop = p; ack = a;
        @(posedge clk);
        model_edge(s, p, a);
        @(negedge clk);
        check_model(where);
    endtask

    task automatic idle_cycles(input int n, input string where);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, where);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; stop = 1'b0; ack = 1'b0;
        model_reset();
        #23;
        chk("reset.elapsed_ms", int'(elapsed_ms), 0);
        chk("reset.result_valid", int'(result_valid), 0);
        chk("reset.timeout", int'(timeout), 0);
        chk("reset.busy", int'(busy), 0);
        @(negedge clk);
        reset = 1'b1;

        // Normal measurement: start at P0, stop at P14 -> 3 ms.
        cyc(1'b1, 1'b0, 1'b0, "normal.P0");
        chk("normal.busy_after_P0", int'(busy), 1);
        idle_cycles(13, "normal.run");
        chk("normal.busy_before_stop", int'(busy), 1);
        cyc(1'b0, 1'b1, 1'b0, "normal.P14");
        chk("normal.elapsed", int'(elapsed_ms), 3);
        chk("normal.valid", int'(result_valid), 1);
        chk("normal.timeout", int'(timeout), 0);
        chk("normal.busy", int'(busy), 0);

        // Hold: start pulse ignored, then ack together with a start rise.
        cyc(1'b0, 1'b0, 1'b0, "hold.settle");
        cyc(1'b1, 1'b0, 1'b0, "hold.start_pulse");
        cyc(1'b0, 1'b0, 1'b0, "hold.start_low");
        chk("hold.still_valid", int'(result_valid), 1);
        chk("hold.still_elapsed", int'(elapsed_ms), 3);
        cyc(1'b1, 1'b0, 1'b1, "hold.ack_start");
        chk("ack.valid_cleared", int'(result_valid), 0);
        chk("ack.timeout_cleared", int'(timeout), 0);
        chk("ack.elapsed_kept", int'(elapsed_ms), 3);
        cyc(1'b0, 1'b0, 1'b0, "ack.after");
        chk("ack.no_run", int'(busy), 0);

        // Fresh run; stop coincident with the tick at P8 -> 1 ms.
        cyc(1'b1, 1'b0, 1'b0, "coinc.P0");
        chk("coinc.busy", int'(busy), 1);
        idle_cycles(7, "coinc.run");
        cyc(1'b0, 1'b1, 1'b0, "coinc.P8");
        chk("coinc.elapsed", int'(elapsed_ms), 1);
        chk("coinc.valid", int'(result_valid), 1);
        cyc(1'b0, 1'b0, 1'b1, "coinc.ack");

        // Timeout: no stop for 40 edges.
        cyc(1'b1, 1'b0, 1'b0, "tmo.P0");
        idle_cycles(39, "tmo.run");
        chk("tmo.busy_P39", int'(busy), 1);
        cyc(1'b0, 1'b0, 1'b0, "tmo.P40");
        chk("tmo.elapsed", int'(elapsed_ms), MAXM);
        chk("tmo.flag", int'(timeout), 1);
        chk("tmo.valid", int'(result_valid), 1);
        chk("tmo.busy", int'(busy), 0);
        idle_cycles(4, "tmo.hold");
        cyc(1'b0, 1'b1, 1'b0, "tmo.P45_stop");
        chk("tmo.stop_ignored_elapsed", int'(elapsed_ms), MAXM);
        chk("tmo.stop_ignored_flag", int'(timeout), 1);
        cyc(1'b0, 1'b0, 1'b1, "tmo.ack");
        chk("tmo.ack_flag", int'(timeout), 0);

        // IDLE: stop alone does nothing; start+stop together starts a run.
        cyc(1'b0, 1'b1, 1'b0, "idle.stop_alone");
        chk("idle.stop_alone_busy", int'(busy), 0);
        chk("idle.stop_alone_valid", int'(result_valid), 0);
        cyc(1'b0, 1'b0, 1'b0, "idle.gap");
        cyc(1'b1, 1'b1, 1'b0, "idle.both");
        chk("idle.both_busy", int'(busy), 1);
        idle_cycles(5, "idle.both_run");
        cyc(1'b0, 1'b1, 1'b0, "idle.second_stop");
        chk("idle.second_stop_elapsed", int'(elapsed_ms), 1);
        cyc(1'b0, 1'b0, 1'b1, "idle.ack");

        // Reset mid-run, start held high through the reset.
        cyc(1'b1, 1'b0, 1'b0, "rst.P0");
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, "rst.run");
        #2 reset = 1'b0;
        #1;
        model_reset();
        chk("rst.elapsed", int'(elapsed_ms), 0);
        chk("rst.valid", int'(result_valid), 0);
        chk("rst.timeout", int'(timeout), 0);
        chk("rst.busy", int'(busy), 0);
        @(negedge clk);
        reset = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, "rst.release");
        chk("rst.restart_busy", int'(busy), 1);
        cyc(1'b0, 1'b0, 1'b0, "rst.run2");
        cyc(1'b0, 1'b1, 1'b0, "rst.stop");
        chk("rst.restart_elapsed", int'(elapsed_ms), 0);
        cyc(1'b0, 1'b0, 1'b1, "rst.ack");

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 99) < 12) ? 1'b1 : 1'b0,
                ($urandom_range(0, 99) < 4)  ? 1'b1 : 1'b0,
                ($urandom_range(0, 99) < 10) ? 1'b1 : 1'b0,
                "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
